// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle processor control unit (fetch/decode/execute/memory/writeback)
module multicycle_control_fsm #(
    parameter logic [3:0] OP_ALU  = 4'h0,
    parameter logic [3:0] OP_ADDI = 4'h1,
    parameter logic [3:0] OP_LW   = 4'h2,
    parameter logic [3:0] OP_SW   = 4'h3,
    parameter logic [3:0] OP_BEQ  = 4'h4,
    parameter logic [3:0] OP_J    = 4'h5,
    parameter logic [3:0] OP_HALT = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       jump,
    output logic       jump_cond,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       halted,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_EXEC_R = 4'd3;
    localparam logic [3:0] S_EXEC_I = 4'd4;
    localparam logic [3:0] S_WB_ALU = 4'd5;
    localparam logic [3:0] S_ADDR   = 4'd6;
    localparam logic [3:0] S_MEM_RD = 4'd7;
    localparam logic [3:0] S_WB_MEM = 4'd8;
    localparam logic [3:0] S_MEM_WR = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_HALT   = 4'd12;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       illegal_q;
    logic       decode_illegal;

    assign state      = state_q;
    assign illegal_op = illegal_q;

    // State register plus the sticky illegal-opcode flag, both cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (decode_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Next-state selection; undefined opcodes fall back to the next fetch
    always_comb begin
        state_d        = S_IDLE;
        decode_illegal = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_ALU:       state_d = S_EXEC_R;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_HALT:      state_d = S_HALT;
                    default: begin
                        state_d        = S_FETCH;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: state_d = S_WB_ALU;
            S_EXEC_I: state_d = S_WB_ALU;
            S_WB_ALU: state_d = S_FETCH;
            S_ADDR:   state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
            S_WB_MEM: state_d = S_FETCH;
            S_MEM_WR: state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore output decode; only the FETCH PC/IR write strobes follow mem_ready
    always_comb begin
        pc_write   = 1'b0;
        jump       = 1'b0;
        jump_cond  = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        halted     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_EXEC_I, S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_WB_ALU: reg_write = 1'b1;
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                jump      = 1'b1;
                jump_cond = 1'b1;
                pc_src    = 2'b01;
            end
            S_JUMP: begin
                jump   = 1'b1;
                pc_src = 2'b10;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       mem_ready = 1'b0;
    logic       pc_write, jump, jump_cond, ir_write, i_or_d, mem_read, mem_write;
    logic       reg_write, mem_to_reg, alu_src_a, halted, illegal_op;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] state;

    int n_assert = 0;
    int n_fail   = 0;
    bit exp_ill  = 1'b0;

    logic [16:0] obs;
    assign obs = {pc_write, jump, jump_cond, pc_src, ir_write, i_or_d, mem_read, mem_write,
                  reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, halted};

    multicycle_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .jump(jump), .jump_cond(jump_cond), .pc_src(pc_src),
        .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .halted(halted), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected control word for each named state, straight from the state descriptions
    function automatic logic [16:0] exp_out(input int st, input bit mr);
        logic pw, j, jc, iw, iod, mrd, mwr, rw, mtr, asa, h;
        logic [1:0] ps, asb, aop;
        {pw, j, jc, iw, iod, mrd, mwr, rw, mtr, asa, h} = '0;
        ps = 2'b00; asb = 2'b00; aop = 2'b00;
        case (st)
            1:  begin mrd = 1; asb = 2'b01; pw = mr; iw = mr; end
            2:  asb = 2'b11;
            3:  begin asa = 1; aop = 2'b10; end
            4:  begin asa = 1; asb = 2'b10; end
            5:  rw = 1;
            6:  begin asa = 1; asb = 2'b10; end
            7:  begin mrd = 1; iod = 1; end
            8:  begin rw = 1; mtr = 1; end
            9:  begin mwr = 1; iod = 1; end
            10: begin asa = 1; aop = 2'b01; j = 1; jc = 1; ps = 2'b01; end
            11: begin j = 1; ps = 2'b10; end
            12: h = 1;
            default: ;
        endcase
        return {pw, j, jc, ps, iw, iod, mrd, mwr, rw, mtr, asa, asb, aop, h};
    endfunction

    function automatic bit is_illegal(input logic [3:0] op);
        return !(op <= 4'h5 || op == 4'hF);
    endfunction

    task automatic check_cycle(input int st, input bit mr);
        check("state", state, st);
        check("outputs", obs, exp_out(st, mr));
        check("illegal_op", illegal_op, exp_ill);
        check("inv_pcw_jump", pc_write & jump, 0);
        check("inv_rd_wr", mem_read & mem_write, 0);
        check("inv_cond", jump_cond & ~jump, 0);
    endtask

    // Walks one instruction through its phase list; wait phases hold while mem_ready is low
    task automatic run_instr(input logic [3:0] op, input int stall, input bit rnd, output int cycles);
        int q[$];
        int st;
        int stalls_left;
        bit mr;
        stalls_left = stall;
        cycles = 0;
        case (op)
            4'h0:    q = '{1, 2, 3, 5};
            4'h1:    q = '{1, 2, 4, 5};
            4'h2:    q = '{1, 2, 6, 7, 8};
            4'h3:    q = '{1, 2, 6, 9};
            4'h4:    q = '{1, 2, 10};
            4'h5:    q = '{1, 2, 11};
            4'hF:    q = '{1, 2, 12};
            default: q = '{1, 2};
        endcase
        while (q.size() > 0) begin
            @(negedge clk);
            st = q[0];
            opcode = op;
            if (rnd) begin
                mr = ($urandom_range(0, 3) != 0);
            end else begin
                mr = !(st == 7 && stalls_left > 0);
                if (st == 7 && stalls_left > 0) stalls_left--;
            end
            mem_ready = mr;
            #1;
            check_cycle(st, mr);
            cycles++;
            if (!((st == 1 || st == 7 || st == 9) && !mr)) begin
                void'(q.pop_front());
                if (st == 2 && is_illegal(op)) exp_ill = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_ill = 1'b0;
        repeat (3) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            check("rst_state", state, 0);
            check("rst_outputs", obs, 0);
            check("rst_illegal", illegal_op, 0);
        end
        rst_n = 1'b1;
        #1;
        check("idle_state", state, 0);
        check("idle_outputs", obs, 0);
    endtask

    initial begin
        int cyc;
        logic [3:0] op;
        int lat[6] = '{4, 4, 5, 4, 3, 3};

        // reset and directed latency for each opcode with memory always ready
        do_reset();
        for (int i = 0; i < 6; i++) begin
            op = 4'(i);
            run_instr(op, 0, 1'b0, cyc);
            check("latency", cyc, lat[i]);
        end

        // load with two memory wait cycles
        run_instr(4'h2, 2, 1'b0, cyc);
        check("lw_stall_latency", cyc, 7);

        // illegal opcode sets the sticky flag, which survives the next instruction
        run_instr(4'h9, 0, 1'b0, cyc);
        check("illegal_latency", cyc, 2);
        run_instr(4'h1, 0, 1'b0, cyc);
        check("illegal_sticky", illegal_op, 1);
        do_reset();
        check("illegal_cleared", illegal_op, 0);

        // randomized instruction mix with random memory stalls
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 14));
            run_instr(op, 0, 1'b1, cyc);
        end

        // halt holds for 20 cycles, then async reset clears it mid-cycle
        run_instr(4'hF, 0, 1'b1, cyc);
        repeat (20) begin
            @(negedge clk);
            opcode = 4'($urandom_range(0, 15));
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            check_cycle(12, mem_ready);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_ill = 1'b0;
        #1;
        check("async_rst_halted", halted, 0);
        check("async_rst_state", state, 0);
        check("async_rst_outputs", obs, 0);
        do_reset();
        run_instr(4'h0, 0, 1'b0, cyc);
        check("post_reset_latency", cyc, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
